// File: rtl/can_tx_framer.sv
// can_tx_framer: CAN 2.0A (11-bit ID) transmit framer.
// Serialises a latched frame one bit per bit_tick, inserts stuff bits from
// SOF through the CRC field, feeds every unstuffed SOF..DATA bit to an
// external can_crc, then appends the CRC, delimiters, ACK, EOF and IFS.
// Optional feature macro: CAN_TX_RTR_EN adds the tx_rtr input (remote frames).
// Supported IFS_BITS range: 0..255.
module can_tx_framer #(
  parameter int IFS_BITS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_tick,
  input  logic        tx_start,
`ifdef CAN_TX_RTR_EN
  input  logic        tx_rtr,
`endif
  input  logic [10:0] tx_id,
  input  logic [3:0]  tx_dlc,
  input  logic [63:0] tx_data,
  input  logic [14:0] crc_reg,
  output logic        crc_clr,
  output logic        crc_en,
  output logic        crc_bit,
  output logic        tx_bit,
  output logic        tx_busy,
  output logic        tx_done
);

  // Field states; the order matters, range compares below rely on it.
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_SOF      = 4'd1;
  localparam logic [3:0] ST_ARB      = 4'd2;
  localparam logic [3:0] ST_CTRL     = 4'd3;
  localparam logic [3:0] ST_DATA     = 4'd4;
  localparam logic [3:0] ST_CRC      = 4'd5;
  localparam logic [3:0] ST_CRC_DEL  = 4'd6;
  localparam logic [3:0] ST_ACK_SLOT = 4'd7;
  localparam logic [3:0] ST_ACK_DEL  = 4'd8;
  localparam logic [3:0] ST_EOF      = 4'd9;
  localparam logic [3:0] ST_IFS      = 4'd10;

  localparam logic [7:0] IFS_LEN = 8'(IFS_BITS);

  // State register: state_reg names the field of the bit sent on the next tick.
  logic [3:0]  state_reg, state_next;
  logic [7:0]  bit_cnt_reg, bit_cnt_next;
  // SOF, ID, RTR, IDE, r0, DLC, DATA packed MSB first; shifted as sent.
  logic [82:0] frame_sr_reg, frame_sr_next;
  logic [13:0] crc_sr_reg, crc_sr_next;
  logic [6:0]  data_bits_reg, data_bits_next;
  logic [2:0]  run_cnt_reg, run_cnt_next;
  logic        last_bit_reg, last_bit_next;
  logic        tx_bit_reg, tx_bit_next;
  logic        crc_en_reg, crc_en_next;
  logic        crc_bit_reg, crc_bit_next;
  logic        crc_clr_reg, crc_clr_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;

  logic        rtr_sel;
  logic [6:0]  data_bits_sel;
  logic        field_bit;
  logic [7:0]  field_len_m1;
  logic [3:0]  next_field;
  logic        covered;
  logic        stuffed_field;
  logic        stuff_due;

`ifdef CAN_TX_RTR_EN
  assign rtr_sel = tx_rtr;
`else
  assign rtr_sel = 1'b0;
`endif

  // Payload length in bits at acceptance: DLC clipped to 8 bytes, none for RTR.
  always_comb begin
    data_bits_sel = 7'd0;
    if (!rtr_sel) begin
      data_bits_sel = tx_dlc[3] ? 7'd64 : {1'b0, tx_dlc[2:0], 3'b000};
    end
  end

  // Decode of the current field: its next bit, length, successor and stuffing.
  always_comb begin
    field_bit    = 1'b1;
    field_len_m1 = 8'd0;
    next_field   = ST_IDLE;
    case (state_reg)
      ST_SOF: begin
        field_bit  = frame_sr_reg[82];
        next_field = ST_ARB;
      end
      ST_ARB: begin
        field_bit    = frame_sr_reg[82];
        field_len_m1 = 8'd11;
        next_field   = ST_CTRL;
      end
      ST_CTRL: begin
        field_bit    = frame_sr_reg[82];
        field_len_m1 = 8'd5;
        next_field   = (data_bits_reg == 7'd0) ? ST_CRC : ST_DATA;
      end
      ST_DATA: begin
        field_bit    = frame_sr_reg[82];
        field_len_m1 = {1'b0, data_bits_reg} - 8'd1;
        next_field   = ST_CRC;
      end
      ST_CRC: begin
        // First CRC bit comes straight from can_crc; the rest from the copy.
        field_bit    = (bit_cnt_reg == 8'd0) ? crc_reg[14] : crc_sr_reg[13];
        field_len_m1 = 8'd14;
        next_field   = ST_CRC_DEL;
      end
      ST_CRC_DEL:  next_field = ST_ACK_SLOT;
      ST_ACK_SLOT: next_field = ST_ACK_DEL;
      ST_ACK_DEL:  next_field = ST_EOF;
      ST_EOF: begin
        field_len_m1 = 8'd6;
        next_field   = ST_IFS;
      end
      default: begin
        field_bit    = 1'b1;
        field_len_m1 = 8'd0;
        next_field   = ST_IDLE;
      end
    endcase
    covered       = (state_reg >= ST_SOF) && (state_reg <= ST_DATA);
    stuffed_field = (state_reg >= ST_SOF) && (state_reg <= ST_CRC);
    // CRC_DEL is included so a stuff bit owed by the CRC tail is still sent.
    stuff_due     = (state_reg >= ST_SOF) && (state_reg <= ST_CRC_DEL) &&
                    (run_cnt_reg == 3'd5);
  end

  // Next-state logic: acceptance in IDLE, one bit (field or stuff) per tick.
  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    frame_sr_next  = frame_sr_reg;
    crc_sr_next    = crc_sr_reg;
    data_bits_next = data_bits_reg;
    run_cnt_next   = run_cnt_reg;
    last_bit_next  = last_bit_reg;
    tx_bit_next    = tx_bit_reg;
    crc_en_next    = 1'b0;
    crc_bit_next   = crc_bit_reg;
    crc_clr_next   = 1'b0;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    if (state_reg == ST_IDLE) begin
      if (tx_start) begin
        frame_sr_next  = {1'b0, tx_id, rtr_sel, 2'b00, tx_dlc, tx_data};
        data_bits_next = data_bits_sel;
        bit_cnt_next   = 8'd0;
        run_cnt_next   = 3'd0;
        state_next     = ST_SOF;
        busy_next      = 1'b1;
        crc_clr_next   = 1'b1;
      end
    end else if (bit_tick) begin
      if (stuff_due) begin
        // Complement of the run; the field bit waits for the next tick.
        tx_bit_next   = ~last_bit_reg;
        last_bit_next = ~last_bit_reg;
        run_cnt_next  = 3'd1;
      end else if ((state_reg == ST_IFS) && (bit_cnt_reg == IFS_LEN)) begin
        // This tick closes the last intermission bit.
        state_next  = ST_IDLE;
        busy_next   = 1'b0;
        done_next   = 1'b1;
        tx_bit_next = 1'b1;
      end else begin
        tx_bit_next = field_bit;
        if (stuffed_field) begin
          run_cnt_next  = ((run_cnt_reg != 3'd0) && (field_bit == last_bit_reg)) ?
                          run_cnt_reg + 3'd1 : 3'd1;
          last_bit_next = field_bit;
        end else begin
          run_cnt_next = 3'd0;
        end
        if (covered) begin
          crc_en_next   = 1'b1;
          crc_bit_next  = field_bit;
          frame_sr_next = {frame_sr_reg[81:0], 1'b0};
        end
        if (state_reg == ST_CRC) begin
          crc_sr_next = (bit_cnt_reg == 8'd0) ? crc_reg[13:0] :
                        {crc_sr_reg[12:0], 1'b0};
        end
        if (state_reg == ST_IFS) begin
          bit_cnt_next = bit_cnt_reg + 8'd1;
        end else if (bit_cnt_reg == field_len_m1) begin
          bit_cnt_next = 8'd0;
          state_next   = next_field;
        end else begin
          bit_cnt_next = bit_cnt_reg + 8'd1;
        end
      end
    end
  end

  // Registers with synchronous reset; reset aborts a frame without tx_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= 8'd0;
      frame_sr_reg  <= '0;
      crc_sr_reg    <= '0;
      data_bits_reg <= 7'd0;
      run_cnt_reg   <= 3'd0;
      last_bit_reg  <= 1'b1;
      tx_bit_reg    <= 1'b1;
      crc_en_reg    <= 1'b0;
      crc_bit_reg   <= 1'b0;
      crc_clr_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      frame_sr_reg  <= frame_sr_next;
      crc_sr_reg    <= crc_sr_next;
      data_bits_reg <= data_bits_next;
      run_cnt_reg   <= run_cnt_next;
      last_bit_reg  <= last_bit_next;
      tx_bit_reg    <= tx_bit_next;
      crc_en_reg    <= crc_en_next;
      crc_bit_reg   <= crc_bit_next;
      crc_clr_reg   <= crc_clr_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  assign tx_bit  = tx_bit_reg;
  assign crc_en  = crc_en_reg;
  assign crc_bit = crc_bit_reg;
  assign crc_clr = crc_clr_reg;
  assign tx_busy = busy_reg;
  assign tx_done = done_reg;

endmodule

// File: tb/tb_can_tx_framer.sv
// tb_can_tx_framer: randomized bench for can_tx_framer. A queue-based frame
// model (field list -> CRC-15 -> stuffing -> tail of ones) gives the expected
// bus bit stream and CRC feed; a behavioural can_crc closes the CRC loop.
module tb_can_tx_framer;
  localparam int IFS_BITS = 3;

  logic        clk;
  logic        rst;
  logic        bit_tick;
  logic        tx_start;
`ifdef CAN_TX_RTR_EN
  logic        tx_rtr;
`endif
  logic [10:0] tx_id;
  logic [3:0]  tx_dlc;
  logic [63:0] tx_data;
  logic [14:0] crc_model;
  logic        crc_clr, crc_en, crc_bit, tx_bit, tx_busy, tx_done;

  int n_compared = 0;
  int n_mismatched = 0;
  int frame_no = 0;

  bit tx_q[$];
  bit crc_q[$];
  bit exp_tx[$];
  bit exp_cov[$];
  logic [14:0] exp_crc;
  int exp_stuffed_len;
  int done_cnt, clr_cnt, hold_err, en_err, busy_err;

  can_tx_framer #(.IFS_BITS(IFS_BITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .bit_tick (bit_tick),
    .tx_start (tx_start),
`ifdef CAN_TX_RTR_EN
    .tx_rtr   (tx_rtr),
`endif
    .tx_id    (tx_id),
    .tx_dlc   (tx_dlc),
    .tx_data  (tx_data),
    .crc_reg  (crc_model),
    .crc_clr  (crc_clr),
    .crc_en   (crc_en),
    .crc_bit  (crc_bit),
    .tx_bit   (tx_bit),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bit-time strobe: one clk wide, 2..4 clk apart.
  initial begin
    int gap;
    gap = 0;
    bit_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (gap == 0) begin
        bit_tick = 1'b1;
        gap = $urandom_range(1, 3);
      end else begin
        bit_tick = 1'b0;
        gap--;
      end
    end
  end

  function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
    logic [14:0] r;
    r = {c[13:0], 1'b0};
    if (b ^ c[14]) r = r ^ 15'h4599;
    return r;
  endfunction

  function automatic logic [14:0] crc15(input bit q[$]);
    logic [14:0] c;
    c = '0;
    foreach (q[i]) c = crc_step(c, q[i]);
    return c;
  endfunction

  // Behavioural can_crc, cleared by rst or crc_clr.
  always @(posedge clk) begin
    if (rst || crc_clr) crc_model <= '0;
    else if (crc_en) crc_model <= crc_step(crc_model, crc_bit);
  end

  // Monitor: sample 1 time unit after each edge, record bus bits and CRC feed.
  always @(posedge clk) begin : mon
    logic tick_s, busy_s, bit_s, rst_s;
    tick_s = bit_tick;
    busy_s = tx_busy;
    bit_s  = tx_bit;
    rst_s  = rst;
    #1;
    if (!rst_s && !tick_s && (tx_bit !== bit_s)) hold_err++;
    if ((crc_en === 1'b1) && !tick_s) en_err++;
    if (crc_en === 1'b1) crc_q.push_back(crc_bit);
    if (crc_clr === 1'b1) clr_cnt++;
    if (tx_done === 1'b1) begin
      done_cnt++;
      if (tx_busy !== 1'b0) busy_err++;
    end else if (tick_s && busy_s === 1'b1) begin
      tx_q.push_back(tx_bit);
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: field list, CRC-15, stuffing over SOF..CRC, tail ones.
  task automatic build_model(input logic [10:0] id, input logic [3:0] dlc,
                             input logic [63:0] data, input logic rtr);
    int nb, run;
    bit prev;
    bit full[$];
    exp_cov.delete();
    exp_tx.delete();
    nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    exp_cov.push_back(1'b0);
    for (int b = 10; b >= 0; b--) exp_cov.push_back(id[b]);
    exp_cov.push_back(rtr);
    exp_cov.push_back(1'b0);
    exp_cov.push_back(1'b0);
    for (int b = 3; b >= 0; b--) exp_cov.push_back(dlc[b]);
    for (int k = 0; k < nb * 8; k++) exp_cov.push_back(data[63 - k]);
    exp_crc = crc15(exp_cov);
    full = exp_cov;
    for (int b = 14; b >= 0; b--) full.push_back(exp_crc[b]);
    run = 0;
    prev = 1'b0;
    foreach (full[i]) begin
      exp_tx.push_back(full[i]);
      run = (run != 0 && full[i] == prev) ? run + 1 : 1;
      prev = full[i];
      if (run == 5) begin
        exp_tx.push_back(!prev);
        prev = !prev;
        run = 1;
      end
    end
    exp_stuffed_len = exp_tx.size();
    repeat (10 + IFS_BITS) exp_tx.push_back(1'b1);
  endtask

  task automatic start_frame(input logic [10:0] id, input logic [3:0] dlc,
                             input logic [63:0] data, input bit align);
    int guard;
    tx_q.delete();
    crc_q.delete();
    done_cnt = 0; clr_cnt = 0; hold_err = 0; en_err = 0; busy_err = 0;
    @(negedge clk); #1;
    guard = 0;
    while (align && !bit_tick && guard < 20) begin
      @(negedge clk); #1;
      guard++;
    end
    tx_id = id; tx_dlc = dlc; tx_data = data;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    check_val($sformatf("f%0d accept tx_bit", frame_no), tx_bit, 1);
    check_val($sformatf("f%0d accept tx_busy", frame_no), tx_busy, 1);
    check_val($sformatf("f%0d accept crc_clr", frame_no), crc_clr, 1);
    // Scramble inputs: the frame must come from the latched copy.
    tx_id = 11'($urandom); tx_dlc = 4'($urandom); tx_data = {$urandom, $urandom};
  endtask

  task automatic finish_frame(input bit poke);
    int guard, run, max_run;
    bit prev, b;
    bit ds[$];
    logic [14:0] got_crc;
    if (poke) begin
      repeat ($urandom_range(10, 60)) @(negedge clk);
      tx_start = 1'b1;
      tx_id = 11'($urandom); tx_dlc = 4'($urandom); tx_data = {$urandom, $urandom};
      @(negedge clk);
      tx_start = 1'b0;
    end
    guard = 0;
    while (done_cnt == 0 && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    check_val($sformatf("f%0d tx_done pulses", frame_no), done_cnt, 1);
    check_val($sformatf("f%0d bit count", frame_no), tx_q.size(), exp_tx.size());
    for (int i = 0; i < tx_q.size() && i < exp_tx.size(); i++) begin
      check_val($sformatf("f%0d tx_bit[%0d]", frame_no, i), tx_q[i], exp_tx[i]);
      if (tx_q[i] != exp_tx[i]) break;
    end
    check_val($sformatf("f%0d crc_en count", frame_no), crc_q.size(), exp_cov.size());
    for (int i = 0; i < crc_q.size() && i < exp_cov.size(); i++) begin
      check_val($sformatf("f%0d crc_bit[%0d]", frame_no, i), crc_q[i], exp_cov[i]);
      if (crc_q[i] != exp_cov[i]) break;
    end
    check_val($sformatf("f%0d crc_clr pulses", frame_no), clr_cnt, 1);
    check_val($sformatf("f%0d tx_bit moved off tick", frame_no), hold_err, 0);
    check_val($sformatf("f%0d crc_en off tick", frame_no), en_err, 0);
    check_val($sformatf("f%0d busy high at done", frame_no), busy_err, 0);
    max_run = 0; run = 0; prev = 1'b0;
    for (int i = 0; i < tx_q.size() && i < exp_stuffed_len; i++) begin
      run = (run != 0 && tx_q[i] == prev) ? run + 1 : 1;
      prev = tx_q[i];
      if (run > max_run) max_run = run;
    end
    check_val($sformatf("f%0d run <= 5", frame_no), max_run <= 5, 1);
    run = 0; prev = 1'b0;
    for (int i = 0; i < tx_q.size() && ds.size() < exp_cov.size() + 15; i++) begin
      b = tx_q[i];
      if (run == 5) begin
        run = 1;
        prev = b;
      end else begin
        ds.push_back(b);
        run = (run != 0 && b == prev) ? run + 1 : 1;
        prev = b;
      end
    end
    if (ds.size() == exp_cov.size() + 15) begin
      for (int k = 0; k < 15; k++) got_crc[14 - k] = ds[exp_cov.size() + k];
      check_val($sformatf("f%0d destuffed crc", frame_no), got_crc, exp_crc);
    end else begin
      check_val($sformatf("f%0d destuffed length", frame_no), ds.size(), exp_cov.size() + 15);
    end
    $display("frame %0d: bits=%0d stuffed_len=%0d crc_feed=%0d crc=%h poke=%0d",
             frame_no, tx_q.size(), exp_stuffed_len, crc_q.size(), exp_crc, poke);
    frame_no++;
  endtask

  task automatic run_frame(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data,
                           input logic rtr, input bit align, input bit poke);
`ifdef CAN_TX_RTR_EN
    tx_rtr = rtr;
`endif
    build_model(id, dlc, data, rtr);
    start_frame(id, dlc, data, align);
    finish_frame(poke);
  endtask

  initial begin
    int guard;
    logic [63:0] d;
    logic r;
    rst = 1'b1; tx_start = 1'b0; tx_id = '0; tx_dlc = '0; tx_data = '0;
`ifdef CAN_TX_RTR_EN
    tx_rtr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_val("reset tx_bit", tx_bit, 1);
    check_val("reset tx_busy", tx_busy, 0);
    check_val("reset tx_done", tx_done, 0);
    check_val("reset crc_en", crc_en, 0);
    check_val("reset crc_bit", crc_bit, 0);
    check_val("reset crc_clr", crc_clr, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_frame(11'h000, 4'd0, 64'h0, 1'b0, 1'b0, 1'b0);
    run_frame(11'h123, 4'd1, 64'hA500_0000_0000_0000, 1'b0, 1'b0, 1'b0);
    run_frame(11'h7FF, 4'd8, {64{1'b1}}, 1'b0, 1'b0, 1'b0);
    run_frame(11'($urandom), 4'd3, {$urandom, $urandom}, 1'b0, 1'b0, 1'b1);
    run_frame(11'($urandom), 4'd2, {$urandom, $urandom}, 1'b0, 1'b1, 1'b0);

    // Reset during DATA: abort with no tx_done, then a clean frame.
    build_model(11'h2A5, 4'd8, {$urandom, $urandom}, 1'b0);
    start_frame(11'h2A5, 4'd8, {$urandom, $urandom}, 1'b0);
    guard = 0;
    while (crc_q.size() < 30 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check_val("abort reached DATA", crc_q.size() >= 30, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("abort tx_bit", tx_bit, 1);
    check_val("abort tx_busy", tx_busy, 0);
    check_val("abort tx_done", tx_done, 0);
    check_val("abort crc_en", crc_en, 0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    repeat (60) @(negedge clk);
    check_val("abort no tx_done", done_cnt, 0);
    check_val("abort idle tx_bit", tx_bit, 1);
    frame_no++;
    run_frame(11'h3C3, 4'd5, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);

`ifdef CAN_TX_RTR_EN
    run_frame(11'($urandom), 4'd4, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0);
    check_val("rtr crc_en count", crc_q.size(), 19);
`endif

    for (int n = 0; n < 10; n++) begin
      case ($urandom_range(0, 2))
        0:       d = {$urandom, $urandom};
        1:       d = '0;
        default: d = {64{1'b1}};
      endcase
`ifdef CAN_TX_RTR_EN
      r = 1'($urandom_range(0, 1));
`else
      r = 1'b0;
`endif
      run_frame(11'($urandom), 4'($urandom_range(0, 15)), d, r,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/can_tx_framer.md
# can_tx_framer

CAN 2.0A (11-bit identifier) transmit framer, one stage upstream of `can_crc`. It serialises a latched frame one bit per bit-time tick, inserts stuff bits and drives the `can_crc` `enable`/`data_in` pair with every CRC-covered unstuffed bit. It then reads back the frozen 15-bit `crc_reg` and appends it, followed by the delimiters, ACK slot, EOF and intermission. The output `tx_bit` feeds the bus driver.

## Interface
- `IFS_BITS`, default 3: number of intermission bits after EOF before `tx_done`.
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `bit_tick`  in  1  one-`clk` strobe marking each bit-time boundary. Consecutive ticks are at least 2 `clk` apart.
- `tx_start`  in  1  frame request; sampled only in IDLE.
- `tx_id`  in  11  identifier, sent MSB first.
- `tx_dlc`  in  4  data length code, sent as given.
- `tx_data`  in  64  payload; byte 0 = `[63:56]`, each byte sent MSB first.
- `crc_reg`  in  15  CRC value returned from `can_crc`.
- `crc_clr`  out  1  one-cycle clear for `can_crc`, ORed with `rst` at the instantiation.
- `crc_en`  out  1  drives `can_crc` `enable`.
- `crc_bit`  out  1  drives `can_crc` `data_in`.
- `tx_bit`  out  1  serial bus bit; 1 = recessive.
- `tx_busy`  out  1  high from the cycle after acceptance until `tx_done`.
- `tx_done`  out  1  one-cycle pulse when the frame is complete.

## Operation
- Reset values: `tx_bit`=1, `tx_busy`=0, `tx_done`=0, `crc_en`=0, `crc_bit`=0, `crc_clr`=0. State is IDLE.
- Acceptance:
  - `tx_start`=1 in IDLE latches `tx_id`, `tx_dlc` and `tx_data`, and pulses `crc_clr` in the same cycle.
  - `tx_start` outside IDLE is ignored.
- States, each advancing on `bit_tick` only:
  - IDLE
  - SOF: 1 bit, value 0.
  - ARB: 11 ID bits, then RTR=0.
  - CTRL: IDE=0, r0=0, then 4 DLC bits.
  - DATA: 8·min(DLC,8) bits; skipped when the count is 0.
  - CRC: 15 bits, MSB first.
  - CRC_DEL: 1.
  - ACK_SLOT: 1; transmitted recessive and not sampled.
  - ACK_DEL: 1.
  - EOF: 7 ones.
  - IFS: `IFS_BITS` ones.
  - IFS then returns to IDLE.
- DLC 9–15 is transmitted unchanged and carries 8 data bytes.
- CRC feed:
  - On the `clk` where `bit_tick`=1 and the next unstuffed bit lies in SOF..DATA, assert `crc_en`=1 for that single cycle, with `crc_bit` equal to that bit.
  - Stuff bits are never fed to `can_crc`.
  - On the first `bit_tick` in CRC, latch `crc_reg` into a shift register, then shift it out.
- Bit stuffing:
  - Applies to `tx_bit` from SOF through the last CRC bit.
  - After 5 consecutive identical transmitted bits (stuff bits included in the run count), the next bit time carries the complement. The field bit is held and the state does not advance.
  - A stuff bit starts a new run of length 1.
  - A stuff bit owed after the last CRC bit is still inserted before CRC_DEL.
  - Stuffing is off from CRC_DEL onwards.
- Reset mid-frame: the next cycle returns to IDLE with all outputs at reset values. No `tx_done` is issued.

## Timing
- `tx_start` accepted at edge N, so `tx_busy`=1 from N+1.
- SOF is driven on the first `bit_tick` strictly after N, including when `bit_tick` and `tx_start` coincide at N.
- `tx_bit` changes only on `clk` edges where `bit_tick`=1 and holds between ticks.
- `crc_en` is high on exactly one `clk` per CRC-covered bit.
- The last `can_crc` update happens at the final DATA (or CTRL) tick. `crc_reg` is read ≥2 `clk` later, at the first CRC tick.
- `tx_done` pulses on the `bit_tick` that ends the last IFS bit. `tx_busy` falls in the same cycle, so a new `tx_start` is accepted on the next cycle.
- Unstuffed frame length is 44 + 8·n + `IFS_BITS` bit times (n = data bytes), plus stuff bits.

## Configuration
- `CAN_TX_RTR_EN` defined:
  - Adds input `tx_rtr` (1 bit), latched at acceptance and sent as the RTR bit.
  - When `tx_rtr`=1, DATA is skipped regardless of DLC, and the DLC is still transmitted.
- Undefined: no `tx_rtr` port, RTR is always 0, and behaviour is as described above.

## Test plan
- ID=0x000, DLC=0: `tx_bit` = 0,0,0,0,0, stuff 1, then zeros continue. 19 `crc_en` pulses; no stuff bit is fed to the CRC.
- ID=0x123, DLC=1, data 0xA5: 27 `crc_en` pulses. The `crc_bit` sequence equals the unstuffed SOF..DATA bits. The CRC field equals a golden CRC-15 (poly 0x4599) of those 27 bits.
- ID=0x7FF, DLC=8, data all 0xFF: after destuffing, captured `tx_bit` rebuilds the frame. Every run of identical bits is ≤5 up to CRC end. EOF is 7 ones. `tx_done` pulses once and `tx_busy` falls with it.
- `tx_start` pulsed while busy, and `tx_start` coincident with `bit_tick` in IDLE: the first is ignored and the frame is unchanged. The second gives SOF on the following tick, not the same one.
- `rst` asserted during DATA: the next cycle shows `tx_bit`=1, `tx_busy`=0 and no `tx_done`. A following `tx_start` sends a clean frame with `crc_clr` pulsed.
- With `CAN_TX_RTR_EN`, `tx_rtr`=1, DLC=4: no DATA bits, 19 `crc_en` pulses, DLC field reads 0100.
